// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

  localparam int unsigned CUR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    NEXT = 2'd2,
    DONE = 2'd3
  } lif_fsm_e;

  // Neuron index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lif_tick_gen.sv
// Timestep prescaler: one-cycle tick every TICK_DIV enabled clock cycles.
module lif_tick_gen #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Gated by ena so a count parked on LAST cannot emit repeated ticks.
  assign tick = ena && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps N_NEURONS virtual neurons through one shared LIF datapath per timestep.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned STATE_W   = 8,
  parameter int unsigned TICK_DIV  = 10_000_000,
  localparam int unsigned IDX_W    = idx_width(N_NEURONS),
  localparam int unsigned SCNT_W   = IDX_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [CUR_W*N_NEURONS-1:0] cur_in,
  output logic                       lif_req,
  output logic [IDX_W-1:0]           lif_idx,
  output logic [CUR_W-1:0]           lif_current,
  output logic [STATE_W-1:0]         lif_state_in,
  input  logic                       lif_ack,
  input  logic [STATE_W-1:0]         lif_state_out,
  input  logic                       lif_spike,
  output logic [N_NEURONS-1:0]       spikes,
  output logic [SCNT_W-1:0]          spike_count,
  output logic                       sweep_done,
  output logic                       overrun,
  input  logic [IDX_W-1:0]           dbg_sel,
  output logic [STATE_W-1:0]         dbg_state
);

  lif_fsm_e             state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [STATE_W-1:0]   mem_q [N_NEURONS];
  logic [N_NEURONS-1:0] acc_q;
  logic                 tick;
  logic                 start, wr, inc, fin;

  lif_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  assign lif_idx      = idx_q;
  assign lif_current  = cur_in[idx_q*CUR_W +: CUR_W];
  assign lif_state_in = mem_q[idx_q];
  assign dbg_state    = mem_q[dbg_sel];

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr      = 1'b0;
    inc     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (lif_ack) begin
          wr      = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          inc     = 1'b1;
          state_d = REQ;
        end
      end
      DONE: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Neuron state store, spike accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      spikes      <= '0;
      spike_count <= '0;
      lif_req     <= 1'b0;
      sweep_done  <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      lif_req    <= (state_d == REQ);
      sweep_done <= (state_d == DONE);
      if (start) begin
        idx_q <= '0;
        acc_q <= '0;
      end
      if (inc) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (wr) begin
        mem_q[idx_q] <= lif_state_out;
        acc_q[idx_q] <= lif_spike;
      end
      if (fin) begin
        spikes      <= acc_q;
        spike_count <= SCNT_W'(popcount16(16'(acc_q)));
      end
      // DONE is not IDLE, so a tick landing on DONE is dropped as well.
      if (tick && (state_q != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler with a behavioural add-and-threshold datapath.
`timescale 1ns/100ps
module tb_lif_scheduler;
  import lif_pkg::*;

  logic        clk, rst_n, ena;
  logic [31:0] cur_in;
  logic        lif_req, lif_ack, lif_spike;
  logic [1:0]  lif_idx, dbg_sel;
  logic [7:0]  lif_current, lif_state_in, lif_state_out, dbg_state;
  logic [3:0]  spikes;
  logic [2:0]  spike_count;
  logic        sweep_done, overrun;

  int vectors = 0;
  int miscompares = 0;

  lif_scheduler #(.N_NEURONS(4), .STATE_W(8), .TICK_DIV(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cur_in(cur_in),
    .lif_req(lif_req), .lif_idx(lif_idx), .lif_current(lif_current),
    .lif_state_in(lif_state_in), .lif_ack(lif_ack),
    .lif_state_out(lif_state_out), .lif_spike(lif_spike),
    .spikes(spikes), .spike_count(spike_count), .sweep_done(sweep_done),
    .overrun(overrun), .dbg_sel(dbg_sel), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: acks ack_delay cycles into each request.
  int unsigned ack_delay = 0;
  int unsigned wait_cnt;
  assign lif_ack       = lif_req && (wait_cnt == ack_delay);
  assign lif_state_out = lif_state_in + lif_current;
  assign lif_spike     = (lif_state_out >= 8'd25);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= 0;
    else if (lif_req && !lif_ack) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  int cyc = 0, tick_cyc = 0, first_req_cyc = 0, sd_cyc = 0, fall_cyc = 0;
  int sd_count = 0, starts = 0, req_seen = 0;
  bit in_sweep = 0;
  logic prev_req = 1'b0;
  logic [1:0] prev_idx;
  logic [7:0] prev_cur, prev_st;
  int idx_log[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_req = 1'b0;
      in_sweep = 0;
    end else begin
      if (dut.u_tick.tick && dut.state_q == IDLE) tick_cyc = cyc;
      if (lif_req) req_seen++;
      if (lif_req && !prev_req) begin
        if (lif_idx == 2'd0) begin
          starts++;
          first_req_cyc = cyc;
          in_sweep = 1;
        end else if (in_sweep) begin
          chk("req_gap", 32'(cyc - fall_cyc), 32'd1);
        end
      end
      if (!lif_req && prev_req) fall_cyc = cyc;
      if (lif_req && prev_req) begin
        chk("idx_stable", 32'(lif_idx), 32'(prev_idx));
        chk("cur_stable", 32'(lif_current), 32'(prev_cur));
        chk("st_stable", 32'(lif_state_in), 32'(prev_st));
      end
      if (lif_req && lif_ack) idx_log.push_back(int'(lif_idx));
      if (sweep_done) begin
        sd_count++;
        sd_cyc = cyc;
        in_sweep = 0;
      end
      prev_req = lif_req;
      prev_idx = lif_idx;
      prev_cur = lif_current;
      prev_st  = lif_state_in;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_sd(input int target, input int budget, input string tag);
    int k;
    for (k = 0; k < budget; k++) begin
      step(1);
      if (sd_count >= target) break;
    end
    chk(tag, 32'(sd_count >= target), 32'd1);
  endtask

  task automatic wait_start(input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      step(1);
      if (starts >= target) break;
    end
    chk("start_timeout", 32'(starts >= target), 32'd1);
  endtask

  task automatic chk_states(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] exp [4];
    exp[0] = s0; exp[1] = s1; exp[2] = s2; exp[3] = s3;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #0.5;
      chk(tag, 32'(dbg_state), 32'(exp[i]));
    end
  endtask

  task automatic chk_log(input string tag);
    chk(tag, 32'(idx_log.size()), 32'd4);
    for (int i = 0; i < idx_log.size() && i < 4; i++) chk(tag, 32'(idx_log[i]), 32'(i));
    idx_log.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  initial begin
    int sd0, st0;
    rst_n = 1'b0; ena = 1'b0; dbg_sel = '0;
    cur_in = {8'd40, 8'd30, 8'd20, 8'd10};

    // Reset then idle with prescaler disabled.
    step(5);
    rst_n = 1'b1;
    step(100);
    chk("idle_req", 32'(req_seen), 32'd0);
    chk("idle_spikes", 32'(spikes), 32'd0);
    chk("idle_count", 32'(spike_count), 32'd0);
    chk("idle_overrun", 32'(overrun), 32'd0);
    chk("idle_sd", 32'(sd_count), 32'd0);
    chk_states("idle_state", 8'd0, 8'd0, 8'd0, 8'd0);

    // First sweep, same-cycle ack.
    ena = 1'b1;
    wait_sd(1, 200, "sweep1_timeout");
    chk("sweep1_lat", 32'(sd_cyc - tick_cyc), 32'd9);
    chk("sweep1_req_lat", 32'(first_req_cyc - tick_cyc), 32'd1);
    chk_log("sweep1_idx");
    step(1);
    chk("sweep1_spikes", 32'(spikes), 32'b1100);
    chk("sweep1_count", 32'(spike_count), 32'd2);
    chk_states("sweep1_state", 8'd10, 8'd20, 8'd30, 8'd40);

    // Second sweep accumulates on top of the first.
    wait_sd(2, 100, "sweep2_timeout");
    chk_log("sweep2_idx");
    step(1);
    ena = 1'b0;
    chk("sweep2_spikes", 32'(spikes), 32'b1110);
    chk("sweep2_count", 32'(spike_count), 32'd3);
    chk("sweep2_overrun", 32'(overrun), 32'd0);
    chk_states("sweep2_state", 8'd20, 8'd40, 8'd60, 8'd80);

    // Delayed ack; prescaler stopped once the sweep is under way.
    do_reset(3);
    idx_log.delete();
    ack_delay = 5;
    st0 = starts;
    sd0 = sd_count;
    ena = 1'b1;
    wait_start(st0 + 1, 100);
    ena = 1'b0;
    wait_sd(sd0 + 1, 200, "delay_timeout");
    chk("delay_lat", 32'(sd_cyc - tick_cyc), 32'd29);
    chk_log("delay_idx");
    step(1);
    chk("delay_spikes", 32'(spikes), 32'b1100);
    chk("delay_count", 32'(spike_count), 32'd2);
    chk("delay_overrun", 32'(overrun), 32'd0);
    chk_states("delay_state", 8'd10, 8'd20, 8'd30, 8'd40);

    // Overrun: sweep far longer than the tick period.
    do_reset(3);
    idx_log.delete();
    ack_delay = 20;
    st0 = starts;
    sd0 = sd_count;
    ena = 1'b1;
    wait_sd(sd0 + 1, 300, "ovr_timeout");
    ena = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_starts", 32'(starts - st0), 32'd1);
    chk_log("ovr_idx");
    step(30);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_sd", 32'(sd_count - sd0), 32'd1);
    chk("ovr_spikes", 32'(spikes), 32'b1100);
    chk_states("ovr_state", 8'd10, 8'd20, 8'd30, 8'd40);

    // Reset while neuron 2 is being requested.
    ack_delay = 3;
    ena = 1'b1;
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        step(1);
        if (lif_req && lif_idx == 2'd2) break;
      end
      chk("mid_reach", 32'(lif_req && lif_idx == 2'd2), 32'd1);
    end
    sd0 = sd_count;
    rst_n = 1'b0;
    #1;
    chk("mid_req", 32'(lif_req), 32'd0);
    chk("mid_idx", 32'(lif_idx), 32'd0);
    chk("mid_overrun", 32'(overrun), 32'd0);
    chk_states("mid_state", 8'd0, 8'd0, 8'd0, 8'd0);
    step(3);
    chk("mid_no_sd", 32'(sd_count - sd0), 32'd0);
    idx_log.delete();
    ack_delay = 0;
    rst_n = 1'b1;
    wait_sd(sd0 + 1, 200, "post_timeout");
    chk_log("post_idx");
    step(1);
    ena = 1'b0;
    chk("post_spikes", 32'(spikes), 32'b1100);
    chk("post_count", 32'(spike_count), 32'd2);
    chk_states("post_state", 8'd10, 8'd20, 8'd30, 8'd40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
